// File: rtl/dispatch_unit.sv
// dispatch_unit: issue stage that allocates a ROB tag, renames rd, resolves operands and drives a one-cycle dispatch bus to RS/LSB
module dispatch_unit #(
    parameter int ROB_W = 5,
    parameter int OP_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rdy,
    input  logic             i_wrong_commit,
    input  logic             i_inst_valid,
    output logic             o_inst_ready,
    input  logic [OP_W-1:0]  i_inst_op,
    input  logic             i_inst_is_ls,
    input  logic             i_inst_has_rd,
    input  logic [4:0]       i_inst_rd,
    input  logic [4:0]       i_inst_rs1,
    input  logic [4:0]       i_inst_rs2,
    input  logic [31:0]      i_inst_imm,
    input  logic [31:0]      i_inst_pc,
    output logic [4:0]       o_rf_rs1,
    output logic [4:0]       o_rf_rs2,
    input  logic [31:0]      i_rf_vi,
    input  logic [31:0]      i_rf_vj,
    input  logic [ROB_W-1:0] i_rf_qi,
    input  logic [ROB_W-1:0] i_rf_qj,
    input  logic             i_rob_rdy_i,
    input  logic             i_rob_rdy_j,
    input  logic [31:0]      i_rob_val_i,
    input  logic [31:0]      i_rob_val_j,
    input  logic             i_rob_full,
    input  logic [ROB_W-1:0] i_rob_next_id,
    output logic             o_rob_alloc,
    output logic             o_rf_rename,
    input  logic             i_alu_valid,
    input  logic [ROB_W-1:0] i_alu_rob_id,
    input  logic [31:0]      i_alu_res,
    input  logic             i_lsb_valid,
    input  logic [ROB_W-1:0] i_lsb_rob_id,
    input  logic [31:0]      i_lsb_res,
    input  logic             i_rs_full,
    input  logic             i_lsb_full,
    output logic             o_rs_dispatch_valid,
    output logic             o_lsb_dispatch_valid,
    output logic [OP_W-1:0]  o_dispatch_op,
    output logic [31:0]      o_dispatch_imm,
    output logic [31:0]      o_dispatch_pc,
    output logic [ROB_W-1:0] o_dispatch_qi,
    output logic [ROB_W-1:0] o_dispatch_qj,
    output logic [31:0]      o_dispatch_vi,
    output logic [31:0]      o_dispatch_vj,
    output logic [ROB_W-1:0] o_dispatch_rd
);
    logic             r_last_vld;
    logic [4:0]       r_last_rd;
    logic [ROB_W-1:0] r_last_tag;
    logic             w_accept;
    logic [4:0]       w_rs     [2];
    logic [ROB_W-1:0] w_rfq    [2];
    logic [31:0]      w_rfv    [2];
    logic             w_rr     [2];
    logic [31:0]      w_rv     [2];
    logic             w_fwd    [2];
    logic [ROB_W-1:0] w_tag    [2];
    logic             w_alu_hit[2];
    logic             w_lsb_hit[2];
    logic             w_rob_hit[2];
    logic [ROB_W-1:0] w_q      [2];
    logic [31:0]      w_v      [2];

    assign o_inst_ready = i_rdy & ~i_wrong_commit & ~i_rob_full & ~(i_inst_is_ls ? i_lsb_full : i_rs_full);
    assign w_accept     = i_inst_valid & o_inst_ready;
    assign o_rob_alloc  = w_accept;
    assign o_rf_rename  = w_accept & i_inst_has_rd & (i_inst_rd != 5'd0);
    assign o_rf_rs1     = i_inst_rs1;
    assign o_rf_rs2     = i_inst_rs2;

    assign w_rs[0]  = i_inst_rs1;
    assign w_rs[1]  = i_inst_rs2;
    assign w_rfq[0] = i_rf_qi;
    assign w_rfq[1] = i_rf_qj;
    assign w_rfv[0] = i_rf_vi;
    assign w_rfv[1] = i_rf_vj;
    assign w_rr[0]  = i_rob_rdy_i;
    assign w_rr[1]  = i_rob_rdy_j;
    assign w_rv[0]  = i_rob_val_i;
    assign w_rv[1]  = i_rob_val_j;

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        // The previous accept's rename lands on this edge, so the regfile tag is stale for that rd.
        assign w_fwd[g]     = r_last_vld & (r_last_rd == w_rs[g]) & (r_last_rd != 5'd0);
        assign w_tag[g]     = w_fwd[g] ? r_last_tag : w_rfq[g];
        assign w_alu_hit[g] = i_alu_valid & (i_alu_rob_id == w_tag[g]);
        assign w_lsb_hit[g] = i_lsb_valid & (i_lsb_rob_id == w_tag[g]);
        // rob_rdy reports on the regfile's tag, so it says nothing about a forwarded tag.
        assign w_rob_hit[g] = ~w_fwd[g] & w_rr[g];
        assign w_q[g] = (w_rs[g] == 5'd0 || w_tag[g] == '0 || w_alu_hit[g] || w_lsb_hit[g] || w_rob_hit[g]) ? '0 : w_tag[g];
        assign w_v[g] = w_rs[g] == 5'd0 ? 32'd0 :
                        w_tag[g] == '0  ? w_rfv[g] :
                        w_alu_hit[g]    ? i_alu_res :
                        w_lsb_hit[g]    ? i_lsb_res :
                        w_rob_hit[g]    ? w_rv[g] : 32'd0;
    end

    // Dispatch bus and rename-forward register; the bus is zeroed on any enabled cycle without an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rs_dispatch_valid  <= 1'b0;
            o_lsb_dispatch_valid <= 1'b0;
            o_dispatch_op        <= '0;
            o_dispatch_imm       <= '0;
            o_dispatch_pc        <= '0;
            o_dispatch_qi        <= '0;
            o_dispatch_qj        <= '0;
            o_dispatch_vi        <= '0;
            o_dispatch_vj        <= '0;
            o_dispatch_rd        <= '0;
            r_last_vld           <= 1'b0;
            r_last_rd            <= '0;
            r_last_tag           <= '0;
        end else if (i_rdy) begin
            o_rs_dispatch_valid  <= w_accept & ~i_inst_is_ls;
            o_lsb_dispatch_valid <= w_accept & i_inst_is_ls;
            o_dispatch_op        <= w_accept ? i_inst_op : '0;
            o_dispatch_imm       <= w_accept ? i_inst_imm : '0;
            o_dispatch_pc        <= w_accept ? i_inst_pc : '0;
            o_dispatch_qi        <= w_accept ? w_q[0] : '0;
            o_dispatch_qj        <= w_accept ? w_q[1] : '0;
            o_dispatch_vi        <= w_accept ? w_v[0] : '0;
            o_dispatch_vj        <= w_accept ? w_v[1] : '0;
            o_dispatch_rd        <= w_accept ? i_rob_next_id : '0;
            r_last_vld           <= o_rf_rename;
            if (w_accept) begin
                r_last_rd  <= i_inst_rd;
                r_last_tag <= i_rob_next_id;
            end
        end
    end
endmodule
